lock_controller: RTL and testbench
==================================

Name: lock_controller

Overview:
- Sequencing stage of the digital lock that sits around the 3-bit digit comparator.
- Collects keypad digits one at a time and presents the stored digit for the current position on code_retrieve to the comparator.
- Samples the comparator's compare result for each digit and, after a full code, decides unlock or fail.
- Also handles re-programming of the stored code and a lockout after repeated failures.

Parameters:
- CODE_LEN, 4, number of 3-bit digits per code (2..8).
- DEFAULT_CODE, 12'b100_011_010_001, reset code; digit 0 in bits [2:0] (code 1-2-3-4). Width is 3*CODE_LEN.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- UNLOCK_CYCLES, 500, clock cycles the lock stays open.
- LOCKOUT_CYCLES, 1000, clock cycles of lockout.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_in  in  3  keypad digit, valid when key_valid=1.
- key_valid  in  1  one-cycle strobe per key press.
- cancel  in  1  abort current entry or programming.
- prog_req  in  1  request to re-program; honoured only in UNLOCKED.
- compare  in  1  comparator result: code_in equals code_retrieve, combinational.
- code_retrieve  out  3  stored digit at current index, to comparator.
- unlocked  out  1  high while in UNLOCKED or PROGRAM.
- lockout  out  1  high while in LOCKOUT.
- fail_count  out  3  consecutive failures.
- digit_idx  out  3  current digit position.

Behaviour:
- Reset (async, rst_n=0): state LOCKED; stored code = DEFAULT_CODE; digit_idx=0; fail_count=0; mismatch flag=0; timer=0; unlocked=0; lockout=0; code_retrieve=DEFAULT_CODE[2:0]. Reset mid-operation discards any entry, programming or timer, and restores DEFAULT_CODE.
- code_retrieve = stored_code[3*digit_idx +: 3], combinational from registers. compare is sampled in the same cycle as key_valid, so there is zero added latency in the loop.
- LOCKED:
  - key_valid: mismatch <= mismatch | ~compare; digit_idx++.
  - On the CODE_LEN-th digit, the decision takes effect next cycle (1-cycle latency) and digit_idx returns to 0.
  - Mismatch sets no early abort; all CODE_LEN digits are always consumed.
  - Pass: -> UNLOCKED, fail_count=0, timer=UNLOCK_CYCLES-1.
  - Fail: fail_count++. If the new count equals MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYCLES-1. Otherwise stay LOCKED.
  - cancel: digit_idx=0, mismatch=0, fail_count unchanged.
- UNLOCKED:
  - Timer decrements each cycle; at 0 -> LOCKED.
  - key_valid is ignored.
  - prog_req -> PROGRAM, digit_idx=0.
  - cancel -> LOCKED immediately.
- PROGRAM:
  - key_valid writes code_in into the shadow register at digit_idx; digit_idx++.
  - The last digit commits shadow to stored code in the same edge -> LOCKED.
  - cancel discards shadow -> LOCKED, stored code unchanged.
  - No timeout; the unlock timer is frozen.
- LOCKOUT:
  - key_valid, cancel and prog_req are ignored.
  - Timer decrements; at 0 -> LOCKED, fail_count=0.
- Simultaneous events:
  - cancel has priority over key_valid in the same cycle.
  - prog_req with key_valid in UNLOCKED: prog_req wins and the key is dropped.
  - Timer expiry in UNLOCKED with prog_req in the same cycle: expiry wins.
- fail_count saturates at MAX_FAIL.
- Timers are sized to clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)).
- Unused code_in values are all legal; 0 is a valid digit.

Decomposition:
- Shared package lock_pkg:
  - state enum: LOCKED, UNLOCKED, PROGRAM, LOCKOUT
  - DIGIT_W=3 constant
  - default code constant
- Sub-module lock_timer: loadable down-counter with load and value inputs and a done output. It is shared by the UNLOCKED and LOCKOUT states.
- The comparator stays external.

Test Plan:
- Reset, then enter 1,2,3,4 with compare driven by a model comparator -> unlocked=1 two cycles after the 4th strobe. It stays high 500 cycles, then unlocked=0.
- Enter 1,2,9→(digit 7),4 -> fail_count=1, unlocked stays 0. digit_idx returns to 0 only after the 4th key, with no early abort.
- Three wrong codes -> lockout=1, fail_count=3. Keys are ignored for 1000 cycles, then lockout=0 and fail_count=0.
- Unlock, prog_req, enter 5,5,0,7 -> LOCKED. Old code 1,2,3,4 now fails and 5,5,0,7 unlocks.
- Unlock, prog_req, enter 2 digits, cancel -> stored code still 1,2,3,4.
- Deassert rst_n during PROGRAM after 3 digits -> all outputs reach their reset values asynchronously and code 1,2,3,4 unlocks afterwards.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the digital lock sequencing stage.
package lock_pkg;

  localparam int DIGIT_W     = 3;
  localparam int DEFAULT_LEN = 4;

  // Code 1-2-3-4 with digit 0 in the low bits.
  localparam logic [DIGIT_W*DEFAULT_LEN-1:0] DEFAULT_CODE = 12'b100_011_010_001;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Holds at zero so a stale enable cannot wrap the count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lock_controller.sv
// Digit sequencer for the lock: feeds stored digits to the external comparator,
// decides unlock/fail after a full code, handles re-programming and lockout.
module lock_controller
  import lock_pkg::*;
#(
  parameter int                           CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]  DEFAULT_CODE   = lock_pkg::DEFAULT_CODE,
  parameter int                           MAX_FAIL       = 3,
  parameter int                           UNLOCK_CYCLES  = 500,
  parameter int                           LOCKOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] code_in,
  input  logic               key_valid,
  input  logic               cancel,
  input  logic               prog_req,
  input  logic               compare,
  output logic [DIGIT_W-1:0] code_retrieve,
  output logic               unlocked,
  output logic               lockout,
  output logic [2:0]         fail_count,
  output logic [2:0]         digit_idx
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int T_MAX  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(T_MAX);

  state_e              state_q,  state_d;
  logic [CODE_W-1:0]   code_q,   code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [2:0]          idx_q,    idx_d;
  logic [2:0]          fail_q,   fail_d;
  logic                mis_q,    mis_d;
  logic                decide_q, decide_d;

  logic [CODE_W-1:0]   shadow_wr;
  logic [2:0]          fail_inc;
  logic                last_key;
  logic                t_load, t_en, t_done;
  logic [TW-1:0]       t_val;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  // Digit mux to the comparator, and the shadow code with the current key merged in.
  always_comb begin
    code_retrieve = '0;
    shadow_wr     = shadow_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == i[2:0]) begin
        code_retrieve                  = code_q[i*DIGIT_W +: DIGIT_W];
        shadow_wr[i*DIGIT_W +: DIGIT_W] = code_in;
      end
    end
  end

  assign last_key = (idx_q == 3'(CODE_LEN - 1));
  assign fail_inc = (fail_q >= 3'(MAX_FAIL)) ? fail_q : fail_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    mis_d    = mis_q;
    decide_d = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    t_en     = 1'b0;
    case (state_q)
      LOCKED: begin
        // The verdict lands one cycle after the last digit; keys that cycle are dropped.
        if (decide_q) begin
          mis_d = 1'b0;
          if (!mis_q) begin
            state_d = UNLOCKED;
            fail_d  = '0;
            t_load  = 1'b1;
            t_val   = TW'(UNLOCK_CYCLES - 1);
          end else begin
            fail_d = fail_inc;
            if (fail_inc == 3'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              t_load  = 1'b1;
              t_val   = TW'(LOCKOUT_CYCLES - 1);
            end
          end
        end else if (cancel) begin
          idx_d = '0;
          mis_d = 1'b0;
        end else if (key_valid) begin
          mis_d = mis_q | ~compare;
          if (last_key) begin
            idx_d    = '0;
            decide_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      UNLOCKED: begin
        t_en = 1'b1;
        if (t_done || cancel) begin
          state_d = LOCKED;
        end else if (prog_req) begin
          state_d = PROGRAM;
          idx_d   = '0;
        end
      end
      PROGRAM: begin
        if (cancel) begin
          state_d = LOCKED;
          idx_d   = '0;
        end else if (key_valid) begin
          shadow_d = shadow_wr;
          if (last_key) begin
            code_d  = shadow_wr;
            state_d = LOCKED;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      LOCKOUT: begin
        t_en = 1'b1;
        if (t_done) begin
          state_d = LOCKED;
          fail_d  = '0;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      idx_q    <= '0;
      fail_q   <= '0;
      mis_q    <= 1'b0;
      decide_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      mis_q    <= mis_d;
      decide_q <= decide_d;
    end
  end

  assign unlocked   = (state_q == UNLOCKED) || (state_q == PROGRAM);
  assign lockout    = (state_q == LOCKOUT);
  assign fail_count = fail_q;
  assign digit_idx  = idx_q;

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller with a model comparator and a
// scoreboard of expected verdicts {lockout, unlocked, fail_count}.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_in;
  logic       key_valid;
  logic       cancel;
  logic       prog_req;
  logic       compare;
  logic [2:0] code_retrieve;
  logic       unlocked;
  logic       lockout;
  logic [2:0] fail_count;
  logic [2:0] digit_idx;

  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         m_fail = 0;
  logic [2:0] mc [4];

  lock_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_in       (code_in),
    .key_valid     (key_valid),
    .cancel        (cancel),
    .prog_req      (prog_req),
    .compare       (compare),
    .code_retrieve (code_retrieve),
    .unlocked      (unlocked),
    .lockout       (lockout),
    .fail_count    (fail_count),
    .digit_idx     (digit_idx)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Model of the external 3-bit digit comparator.
  assign compare = (code_in == code_retrieve);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] d);
    code_in   = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic set_model_code(input logic [2:0] d0, d1, d2, d3);
    mc[0] = d0; mc[1] = d1; mc[2] = d2; mc[3] = d3;
  endtask

  // Drives a full code from LOCKED and checks the verdict one cycle after the last key.
  task automatic enter_code(input logic [2:0] d0, d1, d2, d3);
    logic       match;
    logic       lk;
    logic [4:0] exp;
    match = (d0 == mc[0]) && (d1 == mc[1]) && (d2 == mc[2]) && (d3 == mc[3]);
    if (match) begin
      m_fail = 0;
      exp_q.push_back({1'b0, 1'b1, 3'd0});
    end else begin
      if (m_fail < 3) m_fail++;
      lk = (m_fail == 3);
      exp_q.push_back({lk, 1'b0, 3'(m_fail)});
    end
    press(d0);
    press(d1);
    press(d2);
    check_eq("idx_before_last", 32'(digit_idx), 32'd3);
    press(d3);
    check_eq("idx_wrap", 32'(digit_idx), 32'd0);
    tick();
    exp = exp_q.pop_front();
    check_eq("verdict", 32'({lockout, unlocked, fail_count}), 32'(exp));
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    code_in   = '0;
    key_valid = 1'b0;
    cancel    = 1'b0;
    prog_req  = 1'b0;
    set_model_code(3'd1, 3'd2, 3'd3, 3'd4);
    repeat (3) tick();
    check_eq("rst_unlocked", 32'(unlocked), 32'd0);
    check_eq("rst_lockout", 32'(lockout), 32'd0);
    check_eq("rst_fail", 32'(fail_count), 32'd0);
    check_eq("rst_idx", 32'(digit_idx), 32'd0);
    check_eq("rst_retrieve", 32'(code_retrieve), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Correct code, then measure the unlock window.
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);
    cnt = 1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (unlocked) cnt++;
      else break;
    end
    check_eq("unlock_len", 32'(cnt), 32'd500);

    // Three wrong codes lead to lockout; input noise is ignored throughout.
    enter_code(3'd1, 3'd2, 3'd7, 3'd4);
    enter_code(3'd7, 3'd7, 3'd7, 3'd7);
    enter_code(3'd0, 3'd0, 3'd0, 3'd0);
    cnt = 1;
    for (int i = 0; i < 1200; i++) begin
      key_valid = 1'($urandom_range(0, 1));
      cancel    = 1'($urandom_range(0, 1));
      prog_req  = 1'($urandom_range(0, 1));
      code_in   = 3'($urandom_range(0, 7));
      tick();
      if (lockout) cnt++;
      else break;
    end
    key_valid = 1'b0;
    cancel    = 1'b0;
    prog_req  = 1'b0;
    m_fail    = 0;
    check_eq("lockout_len", 32'(cnt), 32'd1000);
    check_eq("post_lockout_fail", 32'(fail_count), 32'd0);
    check_eq("post_lockout_idx", 32'(digit_idx), 32'd0);

    // Cancel beats a simultaneous key and clears the mismatch.
    press(3'd7);
    press(3'd7);
    cancel = 1'b1;
    press(3'd3);
    cancel = 1'b0;
    check_eq("cancel_idx", 32'(digit_idx), 32'd0);
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("cancel_unlocked", 32'(unlocked), 32'd0);

    // Programming aborted by cancel leaves the stored code alone.
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);
    prog_req = 1'b1;
    press(3'd5);
    prog_req = 1'b0;
    check_eq("prog_unlocked", 32'(unlocked), 32'd1);
    check_eq("prog_key_dropped", 32'(digit_idx), 32'd0);
    press(3'd6);
    press(3'd6);
    check_eq("prog_idx", 32'(digit_idx), 32'd2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("prog_cancel", 32'(unlocked), 32'd0);
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);

    // Re-program to 5,5,0,7.
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(3'd5);
    press(3'd5);
    press(3'd0);
    press(3'd7);
    check_eq("prog_commit", 32'(unlocked), 32'd0);
    set_model_code(3'd5, 3'd5, 3'd0, 3'd7);
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);
    enter_code(3'd5, 3'd5, 3'd0, 3'd7);

    // Async reset in the middle of programming.
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(3'd1);
    press(3'd1);
    press(3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_unlocked", 32'(unlocked), 32'd0);
    check_eq("arst_idx", 32'(digit_idx), 32'd0);
    check_eq("arst_retrieve", 32'(code_retrieve), 32'd1);
    check_eq("arst_lockout", 32'(lockout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_model_code(3'd1, 3'd2, 3'd3, 3'd4);
    m_fail = 0;
    enter_code(3'd5, 3'd5, 3'd0, 3'd7);
    enter_code(3'd1, 3'd2, 3'd3, 3'd4);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
